mmio_uart_tx: RTL and testbench

- Memory-mapped peripheral responder on the CPU data-memory port: address, input_data, mem_read, mem_write, mem_op_length in; output_data out.
- Accepts stores of bytes into a small TX FIFO and serialises them as 8N1 UART frames on uart_tx.
- Exposes status, baud divisor and LED registers for software polling.
- Sits beside data_memory, selected by address range; its output_data is muxed into the MEM-stage read data.

---
 rtl/mmio_uart_tx_pkg.sv | 30 +++
 rtl/mmio_uart_tx_sync_fifo.sv | 69 ++++++
 rtl/mmio_uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, field widths and the serialiser state encoding.
package mmio_uart_tx_pkg;

  // Word offsets (address[3:2]) inside the 16-byte register block
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_BAUD   = 2'd2;
  localparam logic [1:0] UART_LED    = 2'd3;

  // STATUS register bit positions
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;

  localparam int unsigned BAUD_W      = 16;
  localparam int unsigned LED_W       = 5;
  localparam int unsigned CNT_FIELD_W = 5;
  localparam int unsigned BYTE_W      = 8;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with fall-through read data.
// Ports: clock/reset (sync, active-high); push/wdata write side; pop/rdata
// read side; full, empty and count status. A push while full is accepted only
// when a pop happens in the same cycle. Pop while empty is ignored.
module mmio_uart_tx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy update; power-of-two depth lets the pointers wrap naturally
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (8N1) on the CPU data-memory port.
// Ports: clock/reset (sync, active-high); address/input_data/mem_read/
// mem_write/mem_op_length from the MEM stage; output_data combinational load
// data (0 unless a read hits this block); uart_tx registered serial line
// (idle high); led registered LED register.
// Registers: TXDATA (push byte), STATUS, BAUD_DIV, LED.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 234
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] input_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_op_length,
  output logic [31:0] output_data,
  output logic        uart_tx,
  output logic [4:0]  led
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  uart_state_e         state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic                ovf_q, ovf_d;
  logic [BAUD_W-1:0]   cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic                uart_tx_q, uart_tx_d;

  logic                hit;
  logic [1:0]          offset;
  logic                wr_en;
  logic                push_req;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [BYTE_W-1:0]   fifo_rdata;
  logic [BAUD_W-1:0]   period_m1;
  logic                busy;
  logic [31:0]         status_word;
  logic                unused_bits;

  assign unused_bits = ^{mem_op_length, address[1:0], input_data[31:16]};

  assign hit      = (address[31:4] == BASE_ADDR[31:4]);
  assign offset   = address[3:2];
  assign wr_en    = mem_write && hit;
  assign push_req = wr_en && (offset == UART_TXDATA);

  mmio_uart_tx_sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .wdata (input_data[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bit period minus one; a zero divisor behaves as one cycle per bit
  assign period_m1 = (baud_q == '0) ? '0 : baud_q - BAUD_W'(1);

  assign busy = (state_q != UART_IDLE) || (fifo_count != '0);

  always_comb begin
    status_word                                       = '0;
    status_word[STAT_BUSY]                            = busy;
    status_word[STAT_FULL]                            = fifo_full;
    status_word[STAT_EMPTY]                           = fifo_empty;
    status_word[STAT_OVF]                             = ovf_q;
    status_word[STAT_CNT_LSB +: CNT_FIELD_W]          = CNT_FIELD_W'(fifo_count);
  end

  // Load mux: side-effect free, shows pre-write values during a store
  always_comb begin
    output_data = '0;
    if (mem_read && hit) begin
      case (offset)
        UART_STATUS: output_data = status_word;
        UART_BAUD:   output_data = 32'(baud_q);
        UART_LED:    output_data = 32'(led_q);
        default:     output_data = '0;
      endcase
    end
  end

  // Register-file writes; a new overflow wins over a same-cycle clear
  always_comb begin
    baud_d = baud_q;
    led_d  = led_q;
    ovf_d  = ovf_q;
    if (wr_en && (offset == UART_BAUD)) baud_d = input_data[BAUD_W-1:0];
    if (wr_en && (offset == UART_LED))  led_d  = input_data[LED_W-1:0];
    if (wr_en && (offset == UART_STATUS) && input_data[STAT_OVF]) ovf_d = 1'b0;
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // Serialiser next state; divisor is re-sampled at every bit start
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      UART_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = period_m1;
          state_d  = UART_START;
        end
      end
      UART_START: begin
        if (cnt_q == '0) begin
          state_d = UART_DATA;
          bit_d   = '0;
          cnt_d   = period_m1;
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end
      UART_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = period_m1;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = UART_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end
      UART_STOP: begin
        if (cnt_q == '0) state_d = UART_IDLE;
        else             cnt_d   = cnt_q - BAUD_W'(1);
      end
      default: state_d = UART_IDLE;
    endcase
  end

  // Line level follows the current state, so the line lags the FSM by one cycle
  always_comb begin
    uart_tx_d = 1'b1;
    case (state_q)
      UART_START: uart_tx_d = 1'b0;
      UART_DATA:  uart_tx_d = shift_q[0];
      default:    uart_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= UART_IDLE;
      baud_q    <= BAUD_W'(CLKS_PER_BIT);
      led_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      uart_tx_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      led_q     <= led_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      uart_tx_q <= uart_tx_d;
    end
  end

  assign uart_tx = uart_tx_q;
  assign led     = led_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register accesses checked directly,
// transmitted bytes checked through an expected-byte queue and a line decoder.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] input_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  mem_op_length = 3'd2;
  logic [31:0] output_data;
  logic        uart_tx;
  logic [4:0]  led;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (234)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .input_data    (input_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_op_length (mem_op_length),
    .output_data   (output_data),
    .uart_tx       (uart_tx),
    .led           (led)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard and line-decoder state
  logic [7:0] exp_q [$];
  int         start_q [$];
  int         tb_period = 234;
  int         frames_done = 0;
  bit         mon_abort = 1'b0;
  int         mon_p;
  bit         mon_ok;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;
  int         store_cyc;

  initial begin
    forever begin
      @(negedge clock);
      if (uart_tx === 1'b0) begin
        mon_p  = tb_period;
        mon_ok = 1'b1;
        start_q.push_back(cyc);
        for (int i = 1; i < mon_p; i++) begin
          @(negedge clock);
          if (uart_tx !== 1'b0) mon_ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          @(negedge clock);
          mon_byte[b] = uart_tx;
          for (int i = 1; i < mon_p; i++) begin
            @(negedge clock);
            if (uart_tx !== mon_byte[b]) mon_ok = 1'b0;
          end
        end
        for (int i = 0; i < mon_p; i++) begin
          @(negedge clock);
          if (uart_tx !== 1'b1) mon_ok = 1'b0;
        end
        if (mon_abort) begin
          mon_abort = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(mon_byte), 32'hFFFF_FFFF);
        end else begin
          mon_exp = exp_q.pop_front();
          check("frame_data", 32'(mon_byte), 32'(mon_exp));
          check("frame_shape", 32'(mon_ok), 32'd1);
        end
        frames_done++;
      end
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    address    = addr;
    input_data = data;
    mem_write  = 1'b1;
    @(posedge clock);
    #1;
    store_cyc = cyc;
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    address  = addr;
    mem_read = 1'b1;
    #1;
    data     = output_data;
    mem_read = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    wr(BASE + 32'h0, 32'(b));
  endtask

  task automatic set_baud(input int v);
    wr(BASE + 32'h8, 32'(v));
    tb_period = (v == 0) ? 1 : v;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    check("wait_frames", 32'(frames_done), 32'(target));
  endtask

  logic [31:0] r;
  int          base_frames;

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    rd(BASE + 32'h4, r); check("rst_status", r, 32'h4);
    rd(BASE + 32'h8, r); check("rst_baud", r, 32'd234);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_led", 32'(led), 32'd0);

    // Single frame, P=4
    set_baud(4);
    start_q.delete();
    push_byte(8'h55);
    repeat (10) @(posedge clock);
    #1;
    rd(BASE + 32'h4, r); check("busy_mid_frame", r, 32'h5);
    wait_frames(1, 100);
    check("start_latency", 32'(start_q[0] - store_cyc), 32'd2);
    rd(BASE + 32'h4, r); check("idle_after_frame", r, 32'h4);

    // Back-to-back stores, P=2
    set_baud(2);
    start_q.delete();
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    rd(BASE + 32'h4, r); check("b2b_status", r, 32'h4B & ~32'h8);
    wait_frames(6, 400);
    for (int i = 1; i < 5; i++)
      check("b2b_gap", 32'(start_q[i] - start_q[i-1]), 32'd21);
    rd(BASE + 32'h4, r); check("b2b_no_ovf", r & 32'h8, 32'h0);

    // Overflow, P=100
    set_baud(100);
    for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
    wr(BASE + 32'h0, 32'h0000_00EE);
    rd(BASE + 32'h4, r); check("ovf_status", r, 32'h4B);
    wr(BASE + 32'h4, 32'h8);
    rd(BASE + 32'h4, r); check("ovf_cleared", r, 32'h43);
    wait_frames(11, 6000);

    // LED, read-during-write, out-of-range access
    wr(BASE + 32'hC, 32'h1F);
    check("led_out", 32'(led), 32'h1F);
    rd(BASE + 32'hC, r); check("led_read", r, 32'h1F);
    address = BASE + 32'hC; input_data = 32'h0A; mem_write = 1'b1; mem_read = 1'b1;
    #1;
    check("rw_pre_value", output_data, 32'h1F);
    @(posedge clock);
    #1;
    mem_write = 1'b0; mem_read = 1'b0;
    check("rw_led_after", 32'(led), 32'h0A);
    wr(BASE + 32'h10, 32'hFFFF_FFFF);
    rd(BASE + 32'h10, r); check("miss_read", r, 32'h0);
    rd(BASE + 32'hC, r); check("miss_led", r, 32'h0A);
    rd(BASE + 32'h8, r); check("miss_baud", r, 32'd100);
    address = BASE + 32'h8; #1;
    check("no_read_zero", output_data, 32'h0);

    // Reset during DATA bit 3, P=4
    set_baud(4);
    base_frames = frames_done;
    push_byte(8'hA5);
    repeat (18) @(posedge clock);
    #1;
    mon_abort = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_mid_tx", 32'(uart_tx), 32'd1);
    reset = 1'b0;
    rd(BASE + 32'h4, r); check("reset_mid_status", r, 32'h4);
    rd(BASE + 32'h8, r); check("reset_mid_baud", r, 32'd234);
    wait_frames(base_frames + 1, 100);
    set_baud(4);
    push_byte(8'h3C);
    wait_frames(base_frames + 2, 100);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
